// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller and its two digit counters.
// The slave side is the controller; the master side drives the controls and the digit values.
interface stopwatch_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] cnt_ones;
  logic [3:0] cnt_tens;
  logic       en_ones;
  logic       en_tens;
  logic       clr_cnt;
  logic       running;
  logic       done;
  logic [1:0] state;

  modport master (
    output start, stop, clear, cnt_ones, cnt_tens,
    input  en_ones, en_tens, clr_cnt, running, done, state
  );

  modport slave (
    input  start, stop, clear, cnt_ones, cnt_tens,
    output en_ones, en_tens, clr_cnt, running, done, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Two-digit stopwatch controller: prescales clk into count ticks and sequences
// IDLE/RUN/PAUSE/DONE, driving enables and a clear pulse to external 0..9 digit counters.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10,
  parameter bit          WRAP     = 1'b0
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave ctrl_io
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          clr_q, clr_d;

  logic tick;
  logic ones_nine;
  logic terminal;
  logic hold_at_top;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      clr_q   <= clr_d;
    end
  end

  // rst is folded into tick so a tick due in a reset cycle never reaches the counters.
  always_comb begin
    ones_nine   = (ctrl_io.cnt_ones == 4'd9);
    tick        = (state_q == StRun) && (presc_q == PMax) && !ctrl_io.stop && !ctrl_io.clear
                  && !rst;
    terminal    = tick && ones_nine && (ctrl_io.cnt_tens == 4'd9);
    hold_at_top = terminal && !WRAP;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr_d   = ctrl_io.clear;

    if (ctrl_io.clear) begin
      state_d = StIdle;
      presc_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_io.start && !ctrl_io.stop) begin
            state_d = StRun;
            presc_d = '0;
          end
        end
        StRun: begin
          if (ctrl_io.stop) begin
            state_d = StPause;
          end else begin
            presc_d = (presc_q == PMax) ? '0 : presc_q + PW'(1);
            if (hold_at_top) begin
              state_d = StDone;
            end
          end
        end
        // Prescaler is left untouched so the tick phase survives the pause.
        StPause: begin
          if (ctrl_io.start && !ctrl_io.stop) begin
            state_d = StRun;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ctrl_io.en_ones = tick && !hold_at_top;
    ctrl_io.en_tens = tick && ones_nine && !hold_at_top;
    ctrl_io.clr_cnt = clr_q;
    ctrl_io.running = (state_q == StRun);
    ctrl_io.done    = (state_q == StDone);
    ctrl_io.state   = state_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a WRAP=0 and a WRAP=1 instance with TICK_DIV=4, each with two
// digit counters, driven in lockstep and compared every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int TDiv = 4;

  logic clk;
  logic rst;

  stopwatch_ctrl_if sif0 ();
  stopwatch_ctrl_if sif1 ();

  stopwatch_ctrl #(.TICK_DIV(TDiv), .WRAP(1'b0)) u_dut0 (.clk(clk), .rst(rst), .ctrl_io(sif0));
  stopwatch_ctrl #(.TICK_DIV(TDiv), .WRAP(1'b1)) u_dut1 (.clk(clk), .rst(rst), .ctrl_io(sif1));

  // Digit counters attached to each controller.
  logic [3:0] ones0, tens0, ones1, tens1;

  always_ff @(posedge clk) begin
    if (sif0.clr_cnt) begin
      ones0 <= 4'd0;
      tens0 <= 4'd0;
    end else begin
      if (sif0.en_ones) ones0 <= (ones0 == 4'd9) ? 4'd0 : ones0 + 4'd1;
      if (sif0.en_tens) tens0 <= (tens0 == 4'd9) ? 4'd0 : tens0 + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sif1.clr_cnt) begin
      ones1 <= 4'd0;
      tens1 <= 4'd0;
    end else begin
      if (sif1.en_ones) ones1 <= (ones1 == 4'd9) ? 4'd0 : ones1 + 4'd1;
      if (sif1.en_tens) tens1 <= (tens1 == 4'd9) ? 4'd0 : tens1 + 4'd1;
    end
  end

  assign sif0.cnt_ones = ones0;
  assign sif0.cnt_tens = tens0;
  assign sif1.cnt_ones = ones1;
  assign sif1.cnt_tens = tens1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: mode 0 idle, 1 run, 2 pause, 3 done; phase = cycles since last tick;
  // val = displayed number 0..99 (-1 while the counters are still unknown).
  int m_mode[2];
  int m_phase[2];
  int m_val[2];
  bit m_clr[2];
  bit wraps[2];

  int n_pass;
  int n_tot;

  task automatic chk(input string tag, input int idx, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
  endtask

  function automatic void model_en(input int i, input bit r, input bit so, input bit cl,
                                   output bit eo, output bit et);
    bit tick;
    bit top;
    tick = (m_mode[i] == 1) && (m_phase[i] == TDiv - 1) && !so && !cl && !r;
    top  = tick && (m_val[i] == 99);
    eo   = tick && !(top && !wraps[i]);
    et   = eo && (m_val[i] % 10 == 9);
  endfunction

  task automatic check_dut(input int i, input bit r, input bit so, input bit cl);
    bit eo, et;
    logic [1:0] st;
    logic [3:0] on, tn;
    logic e1, e2, cc, rn, dn;
    model_en(i, r, so, cl, eo, et);
    if (i == 0) begin
      st = sif0.state; e1 = sif0.en_ones; e2 = sif0.en_tens; cc = sif0.clr_cnt;
      rn = sif0.running; dn = sif0.done; on = ones0; tn = tens0;
    end else begin
      st = sif1.state; e1 = sif1.en_ones; e2 = sif1.en_tens; cc = sif1.clr_cnt;
      rn = sif1.running; dn = sif1.done; on = ones1; tn = tens1;
    end
    chk("state", i, {6'd0, st}, 8'(m_mode[i]));
    chk("running", i, {7'd0, rn}, {7'd0, m_mode[i] == 1});
    chk("done", i, {7'd0, dn}, {7'd0, m_mode[i] == 3});
    chk("clr_cnt", i, {7'd0, cc}, {7'd0, m_clr[i]});
    chk("en_ones", i, {7'd0, e1}, {7'd0, eo});
    chk("en_tens", i, {7'd0, e2}, {7'd0, et});
    if (m_val[i] >= 0) begin
      chk("digit_ones", i, {4'd0, on}, 8'(m_val[i] % 10));
      chk("digit_tens", i, {4'd0, tn}, 8'(m_val[i] / 10));
    end
  endtask

  task automatic model_update(input int i, input bit r, input bit sa, input bit so,
                              input bit cl);
    bit eo, et;
    model_en(i, r, so, cl, eo, et);
    if (m_clr[i]) m_val[i] = 0;
    else if (eo && m_val[i] >= 0) m_val[i] = (m_val[i] + 1) % 100;
    m_clr[i] = r || cl;
    if (r || cl) begin
      m_mode[i]  = 0;
      m_phase[i] = 0;
    end else if (m_mode[i] == 0) begin
      if (sa && !so) begin
        m_mode[i]  = 1;
        m_phase[i] = 0;
      end
    end else if (m_mode[i] == 1) begin
      if (so) begin
        m_mode[i] = 2;
      end else begin
        if (m_phase[i] == TDiv - 1 && m_val[i] == 0 && !wraps[i] && eo == 0 && et == 0
            && m_val[i] != 0) begin
          m_mode[i] = 3;
        end
        // Reaching 99 and ticking again finishes a non-wrapping watch.
        if (m_phase[i] == TDiv - 1 && !wraps[i] && !eo) m_mode[i] = 3;
        m_phase[i] = (m_phase[i] + 1) % TDiv;
      end
    end else if (m_mode[i] == 2) begin
      if (sa && !so) m_mode[i] = 1;
    end
  endtask

  task automatic step(input bit r, input bit sa, input bit so, input bit cl);
    rst = r;
    sif0.start = sa; sif0.stop = so; sif0.clear = cl;
    sif1.start = sa; sif1.stop = so; sif1.clear = cl;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_dut(i, r, so, cl);
    for (int i = 0; i < 2; i++) model_update(i, r, sa, so, cl);
    @(posedge clk);
    #1;
  endtask

  // Idle-step until DUT1's model is running at the given prescaler phase.
  task automatic run_to_phase(input int ph, input string tag);
    int k;
    k = 0;
    while (!(m_mode[1] == 1 && m_phase[1] == ph) && k < 20) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    chk(tag, 1, 8'(m_phase[1]), 8'(ph));
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    wraps[0] = 1'b0;
    wraps[1] = 1'b1;
    rst = 1'b1;
    sif0.start = 1'b0; sif0.stop = 1'b0; sif0.clear = 1'b0;
    sif1.start = 1'b0; sif1.stop = 1'b0; sif1.clear = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_mode[i]  = 0;
      m_phase[i] = 0;
      m_val[i]   = -1;
      m_clr[i]   = 1'b1;
    end

    // Second reset cycle, then start and count through 01..10.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 42; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reach_10", 0, 8'(m_val[0]), 8'd10);

    // Pause at prescaler 2 for five cycles, then resume.
    run_to_phase(2, "phase_before_stop");
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Run past 99: DUT0 stops in DONE, DUT1 wraps.
    for (int k = 0; k < 400; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_mode", 0, 8'(m_mode[0]), 8'd3);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // clear, stop and start together on a tick cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_phase(TDiv - 1, "phase_before_clear");
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // rst on a tick cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_to_phase(TDiv - 1, "phase_before_rst");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Random control traffic.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10: clk cycles per count tick, legal range 2..65535.
REQ-002 The block SHALL have parameter WRAP, default 0: 1 = wrap 99->00 and keep running; 0 = hold at 99 and stop.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: level, sampled every cycle; run or resume request.
REQ-006 The block SHALL have port stop, input, 1 bit: level, sampled every cycle; pause request.
REQ-007 The block SHALL have port clear, input, 1 bit: level, sampled every cycle; return to IDLE and zero the counters.
REQ-008 The block SHALL have port cnt_ones, input, 4 bits: current value of the ones-digit counter_0_to_9.
REQ-009 The block SHALL have port cnt_tens, input, 4 bits: current value of the tens-digit counter_0_to_9.
REQ-010 The block SHALL have port en_ones, output, 1 bit: count enable to the ones-digit counter.
REQ-011 The block SHALL have port en_tens, output, 1 bit: count enable to the tens-digit counter.
REQ-012 The block SHALL have port clr_cnt, output, 1 bit: registered synchronous clear pulse to both digit counters.
REQ-013 The block SHALL have port running, output, 1 bit: high iff state == RUN.
REQ-014 The block SHALL have port done, output, 1 bit: high iff state == DONE.
REQ-015 The block SHALL have port state, output, 2 bits: encoding IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, PAUSE and DONE.
REQ-017 The block SHALL resolve simultaneous controls with priority clear > stop > start.
REQ-018 The block SHALL take transition IDLE -> RUN on start, clearing the prescaler to 0.
REQ-019 The block SHALL take transition RUN -> PAUSE on stop.
REQ-020 The block SHALL take transition PAUSE -> RUN on start, keeping the prescaler value so the tick phase is preserved.
REQ-021 The block SHALL take transition RUN -> DONE on the terminal tick, only when WRAP=0.
REQ-022 The block SHALL treat DONE as sticky: start and stop are ignored there; only clear or rst leave it.
REQ-023 The block SHALL, when clear is sampled in any state: next state IDLE; prescaler 0; clr_cnt = 1 for exactly the next cycle; clear held high for N cycles yields N clr_cnt cycles.
REQ-024 The block SHALL give start in RUN, and stop in IDLE, PAUSE or DONE, no effect.
REQ-025 The block SHALL use a prescaler of width ceil(log2(TICK_DIV)) that counts 0..TICK_DIV-1 and wraps to 0, only in RUN; it holds in all other states.
REQ-026 The block SHALL define tick = (state == RUN) && (prescaler == TICK_DIV-1) && !stop && !clear.
REQ-027 The block SHALL drive en_ones combinationally = tick, asserted in the same cycle so the counter increments on that edge; one pulse every TICK_DIV cycles.
REQ-028 The block SHALL drive en_tens combinationally = tick && (cnt_ones == 9).
REQ-029 The block SHALL define terminal tick = tick && cnt_ones == 9 && cnt_tens == 9.
REQ-030 The block SHALL, on a terminal tick with WRAP=0, force en_ones = en_tens = 0 so the counters hold at 99, and go to DONE.
REQ-031 The block SHALL, on a terminal tick with WRAP=1, assert both enables so the counters wrap to 00, and remain in RUN.
REQ-032 The block SHALL guarantee en_ones and en_tens are never high outside RUN, or in a cycle where stop or clear is high.
REQ-033 The block SHALL produce no enable in the cycle a stop is sampled; the prescaler freezes at its current value, and that value is not advanced.
REQ-034 The block SHALL treat cnt inputs > 9 as illegal: digit values other than 9 produce no carry; no further checking is required.

Reset
REQ-035 The block SHALL, with rst high at a rising edge: state = IDLE, prescaler = 0, clr_cnt = 1 for the following cycle, running = 0, done = 0.
REQ-036 The block SHALL give rst priority over clear, stop and start.
REQ-037 The block SHALL drive en_ones = en_tens = 0 while in reset-induced IDLE.
REQ-038 The block SHALL, on rst mid-RUN, suppress any tick due in that cycle.

Verification
Run all scenarios with TICK_DIV=4 and two counter_0_to_9 instances attached.
REQ-039 The bench SHALL cover: rst 2 cycles, then start 1 cycle -> state=01; en_ones pulses every 4th cycle; digits read 01, 02 ... 09, then 10 with en_tens high on the 9->0 cycle.
REQ-040 The bench SHALL cover: stop asserted at prescaler=2 for 5 cycles, then start -> state=10 during stop; no enables; first en_ones exactly 2 cycles after resume (phase kept).
REQ-041 The bench SHALL cover: WRAP=0, run to 99 -> next tick: no enables, state=11, done=1, digits stay 99; start and stop ignored; clear -> state=00, clr_cnt 1 cycle, digits 00.
REQ-042 The bench SHALL cover: WRAP=1, run past 99 -> digits 00, en_ones and en_tens both high on that tick, state stays 01.
REQ-043 The bench SHALL cover: clear, stop and start all high in one RUN cycle that would tick -> no enable; state=00; clr_cnt pulse.
REQ-044 The bench SHALL cover: rst asserted mid-RUN on a tick cycle -> no enable; state=00; prescaler 0; clr_cnt 1 the following cycle.
